uart_tx_buffer: RTL and testbench
=================================

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 Parameter DEPTH, default 8, meaning FIFO depth in bytes; legal values are powers of two from 2 to 64.
REQ-002 clk  input  1  single system clock; all logic is clocked on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 wr_en  input  1  write strobe; qualifies wr_data for one cycle.
REQ-005 wr_data  input  8  byte to enqueue.
REQ-006 flush  input  1  synchronous clear of queued (not yet issued) bytes.
REQ-007 tx_done  input  1  one-cycle completion pulse from the transmitter.
REQ-008 tx_start  output  1  one-cycle start pulse to the transmitter.
REQ-009 tx_data  output  8  byte presented to the transmitter; stable between tx_start pulses.
REQ-010 full  output  1  high when count == DEPTH (combinational from count).
REQ-011 empty  output  1  high when count == 0 (combinational from count).
REQ-012 count  output  log2(DEPTH)+1  number of queued bytes.
REQ-013 busy  output  1  high when state == WAIT_DONE or count != 0.
REQ-014 overflow  output  1  registered one-cycle pulse on a dropped write.

Function
REQ-015 Storage shall be a circular buffer of DEPTH x 8 bits with rd_ptr and wr_ptr of width log2(DEPTH), wrapping from DEPTH-1 to 0.
REQ-016 A write shall be accepted at a rising edge when wr_en=1 and full=0: mem[wr_ptr] <= wr_data, and wr_ptr increments.
REQ-017 wr_en=1 while full=1 shall drop the byte, leave storage, pointers and count unchanged, and set overflow=1 for the next cycle only.
REQ-018 The full test shall use the count value before the edge, so a write while full is dropped even if a pop happens on the same edge.
REQ-019 An accepted write and a pop on the same edge shall leave count unchanged while both pointers advance.
REQ-020 The FSM shall have two states: IDLE and WAIT_DONE.
REQ-021 In IDLE with count != 0 and flush=0, the next edge shall set tx_start=1, tx_data <= mem[rd_ptr], increment rd_ptr, decrement count, and move to WAIT_DONE.
REQ-022 tx_start shall be registered and high for exactly one cycle per byte, and shall never be high outside the IDLE->WAIT_DONE transition.
REQ-023 In WAIT_DONE, tx_done=1 shall return the FSM to IDLE at the next edge; otherwise the FSM stays in WAIT_DONE indefinitely.
REQ-024 tx_done while in IDLE shall be ignored.
REQ-025 Latency: a write accepted at edge k into an empty buffer with FSM in IDLE shall produce tx_start=1 in the cycle after edge k+1.
REQ-026 Back-to-back: if tx_done is sampled at edge m and count != 0, the next tx_start=1 shall occur in the cycle after edge m+1 (one IDLE cycle between bytes).
REQ-027 flush=1 at an edge shall set rd_ptr=wr_ptr=0 and count=0, and suppress any pop or write on that edge.
REQ-028 flush shall not affect FSM state, tx_data or an in-flight byte; WAIT_DONE still waits for tx_done.
REQ-029 tx_data shall hold its last issued value until the next tx_start.

Reset
REQ-030 On rst=0 asynchronously: state=IDLE, rd_ptr=wr_ptr=0, count=0, tx_start=0, tx_data=8'h00, overflow=0.
REQ-031 Reset outputs shall therefore be empty=1, full=0, busy=0.
REQ-032 Reset asserted mid-transfer shall abandon the in-flight byte, and no tx_start shall occur until after rst is released.
REQ-033 Storage contents need no reset.
REQ-034 The first edge after release shall behave as IDLE with an empty buffer.

Verification
REQ-035 Single byte: write 8'h6B into an empty buffer -> tx_start pulse two edges later with tx_data=8'h6B, count returns to 0, busy=1 until the FSM returns to IDLE after tx_done.
REQ-036 Burst and order: write 8'hA1, 8'hB2, 8'hC3 on consecutive cycles, then return tx_done 20 cycles after each tx_start -> three tx_start pulses carrying A1, B2, C3 in order, each one cycle after the preceding tx_done edge.
REQ-037 Overflow and full: with DEPTH=8 and tx_done withheld, 10 writes -> first byte issued, next 8 stored with full=1, 10th write dropped with one overflow pulse, count=8.
REQ-038 Simultaneous write+pop at count=3 -> count stays 3, FIFO order preserved; wrap-around checked by pushing 2*DEPTH+3 bytes total and verifying output sequence.
REQ-039 Flush and reset: flush with 5 bytes queued during WAIT_DONE -> count=0, no further tx_start after tx_done; separately, drive rst=0 mid-WAIT_DONE -> all REQ-030 values immediately, no tx_start until new writes.

Source files
------------

// File: rtl/uart_tx_buffer_if.sv
// uart_tx_buffer_if: write-side and transmitter-side signals of the UART TX buffer
interface uart_tx_buffer_if #(parameter int DEPTH = 8);
  logic wr_en, flush, tx_done, tx_start, full, empty, busy, overflow;
  logic [7:0] wr_data, tx_data;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output wr_en, wr_data, flush, tx_done,
    input tx_start, tx_data, full, empty, count, busy, overflow
  );
  modport slave (
    input wr_en, wr_data, flush, tx_done,
    output tx_start, tx_data, full, empty, count, busy, overflow
  );
endinterface

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO that issues one byte at a time to a UART transmitter via start/done handshake
module uart_tx_buffer #(parameter int DEPTH = 8) (
  input logic clk,
  input logic rst,
  uart_tx_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, WAIT_DONE} state_t;
  state_t state;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic pop, push;
  always_comb begin
    pop = state == IDLE && count != '0 && !bus.flush;
    push = bus.wr_en && !bus.full && !bus.flush;
  end
  assign bus.full = count == (AW+1)'(DEPTH);
  assign bus.empty = count == '0;
  assign bus.busy = state == WAIT_DONE || count != '0;
  assign bus.count = count;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.wr_data;
  // full is judged on the pre-edge count, so a pop on the same edge never rescues a write
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      bus.tx_start <= 1'b0;
      bus.tx_data <= 8'h00;
      bus.overflow <= 1'b0;
    end else begin
      bus.tx_start <= pop;
      bus.overflow <= bus.wr_en && bus.full;
      if (pop) bus.tx_data <= mem[rd_ptr];
      state <= pop ? WAIT_DONE : (state == WAIT_DONE && bus.tx_done) ? IDLE : state;
      if (bus.flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
    end
endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: scoreboard bench; stimulus queues expected bytes, a monitor checks every tx_start
module tb_uart_tx_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  uart_tx_buffer_if #(.DEPTH(8)) bus();
  uart_tx_buffer #(.DEPTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [7:0] q [$];
  int n_cmp = 0, n_bad = 0, cyc = 0, done_edge = 0, done_dly = 3;
  bit done_en = 1'b1, have_done = 1'b0, chk_gap = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.wr_en = 1'b0;
      bus.flush = 1'b0;
    end
  endtask

  task automatic put(input logic [7:0] b, input bit acc);
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.wr_data = b;
    bus.flush = 1'b0;
    if (acc) q.push_back(b);
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while ((bus.busy || q.size() != 0) && t < budget) begin
      idle(1);
      t++;
    end
    chk("drain", {31'd0, bus.busy}, 32'd0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // transmitter model: answers each tx_start with tx_done after done_dly cycles when enabled
  initial begin
    int cnt;
    bit pend;
    cnt = 0;
    pend = 1'b0;
    bus.tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_done = 1'b0;
      if (!rst) pend = 1'b0;
      else begin
        if (pend) begin
          cnt++;
          if (done_en && cnt >= done_dly) begin
            bus.tx_done = 1'b1;
            pend = 1'b0;
            done_edge = cyc + 1;
            have_done = 1'b1;
          end
        end
        if (bus.tx_start) begin
          pend = 1'b1;
          cnt = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst && bus.tx_start) begin
        if (q.size() == 0) chk("unexpected_tx_start", 32'd1, 32'd0);
        else begin
          chk("tx_data_order", {24'd0, bus.tx_data}, {24'd0, q.pop_front()});
          if (chk_gap && have_done) chk("b2b_gap", cyc, done_edge + 1);
        end
        have_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_empty", {31'd0, bus.empty}, 32'd1);
    chk("rst_full", {31'd0, bus.full}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_count", {28'd0, bus.count}, 32'd0);
    chk("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
    chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    rst = 1'b1;
    put(8'h6B, 1'b1);
    idle(1);
    chk("lat_no_start_yet", {31'd0, bus.tx_start}, 32'd0);
    chk("lat_count1", {28'd0, bus.count}, 32'd1);
    idle(1);
    chk("lat_start", {31'd0, bus.tx_start}, 32'd1);
    chk("lat_data", {24'd0, bus.tx_data}, 32'h6B);
    chk("lat_count0", {28'd0, bus.count}, 32'd0);
    chk("lat_busy", {31'd0, bus.busy}, 32'd1);
    wait_idle(50);
    chk("hold_tx_data", {24'd0, bus.tx_data}, 32'h6B);
    chk("single_empty", {31'd0, bus.empty}, 32'd1);
    done_dly = 20;
    have_done = 1'b0;
    chk_gap = 1'b1;
    put(8'hA1, 1'b1);
    put(8'hB2, 1'b1);
    put(8'hC3, 1'b1);
    wait_idle(200);
    chk_gap = 1'b0;
    done_en = 1'b0;
    done_dly = 2;
    for (int i = 0; i < 10; i++) put(8'hD0 + 8'(i), i < 9);
    chk("full_set", {31'd0, bus.full}, 32'd1);
    chk("full_count", {28'd0, bus.count}, 32'd8);
    chk("no_ovf_yet", {31'd0, bus.overflow}, 32'd0);
    idle(1);
    chk("ovf_pulse", {31'd0, bus.overflow}, 32'd1);
    chk("ovf_count", {28'd0, bus.count}, 32'd8);
    idle(1);
    chk("ovf_one_cycle", {31'd0, bus.overflow}, 32'd0);
    done_en = 1'b1;
    wait_idle(200);
    done_en = 1'b0;
    for (int i = 0; i < 4; i++) put(8'hE0 + 8'(i), 1'b1);
    idle(1);
    chk("sim_pre_count", {28'd0, bus.count}, 32'd3);
    done_en = 1'b1;
    idle(1);
    put(8'hE4, 1'b1);
    done_en = 1'b0;
    idle(1);
    chk("sim_start", {31'd0, bus.tx_start}, 32'd1);
    chk("sim_count", {28'd0, bus.count}, 32'd3);
    done_en = 1'b1;
    done_dly = 0;
    wait_idle(100);
    for (int i = 0; i < 6; i++) put(8'hF0 + 8'(i), 1'b1);
    wait_idle(100);
    done_en = 1'b0;
    for (int i = 0; i < 6; i++) put(8'h50 + 8'(i), 1'b1);
    idle(1);
    chk("flush_pre_count", {28'd0, bus.count}, 32'd5);
    @(negedge clk);
    bus.flush = 1'b1;
    bus.wr_en = 1'b0;
    q.delete();
    idle(1);
    chk("flush_count", {28'd0, bus.count}, 32'd0);
    chk("flush_empty", {31'd0, bus.empty}, 32'd1);
    chk("flush_busy", {31'd0, bus.busy}, 32'd1);
    chk("flush_tx_data", {24'd0, bus.tx_data}, 32'h50);
    done_en = 1'b1;
    idle(20);
    chk("flush_done_idle", {31'd0, bus.busy}, 32'd0);
    done_en = 1'b0;
    put(8'h70, 1'b1);
    put(8'h71, 1'b1);
    put(8'h72, 1'b1);
    idle(2);
    chk("prerst_count", {28'd0, bus.count}, 32'd2);
    rst = 1'b0;
    q.delete();
    #1;
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_count", {28'd0, bus.count}, 32'd0);
    chk("arst_empty", {31'd0, bus.empty}, 32'd1);
    chk("arst_full", {31'd0, bus.full}, 32'd0);
    chk("arst_tx_start", {31'd0, bus.tx_start}, 32'd0);
    chk("arst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    chk("arst_overflow", {31'd0, bus.overflow}, 32'd0);
    idle(2);
    rst = 1'b1;
    idle(10);
    chk("postrst_idle", {31'd0, bus.busy}, 32'd0);
    done_en = 1'b1;
    put(8'h7E, 1'b1);
    wait_idle(50);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
